p2l_stretcher: RTL and testbench

Pulse-to-level stretcher: the output-side counterpart of the debounce/level-to-pulse stage. Converts single-cycle trigger pulses into a clean, glitch-free high level of guaranteed length, followed by a guaranteed low gap. Used to drive LEDs, slow peripherals and scope-visible strobes from one-cycle events. Dropped triggers are counted for diagnostics.

---
 rtl/p2l_stretcher.sv | 101 ++++++++++
 tb/tb_p2l_stretcher.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/p2l_stretcher.sv
// p2l_stretcher: stretches one-cycle triggers into a fixed-length high level
// followed by a guaranteed low gap, counting rejected triggers.
module p2l_stretcher #(
  parameter int HOLD_CYCLES = 100,
  parameter int GAP_CYCLES  = 10,
  parameter bit RETRIGGER   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       signal_in,
  input  logic       clear_drops,
  output logic       signal_out,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD =
    (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          drop;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    drop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (signal_in) begin
          state_nx = HOLD;
          cnt_nx   = HOLD_LD;
        end
      end
      HOLD: begin
        // an accepted retrigger beats expiry, even on the cnt=0 cycle
        if (signal_in && RETRIGGER) begin
          cnt_nx = HOLD_LD;
        end else begin
          drop = signal_in;
          if (cnt != '0) begin
            cnt_nx = cnt - ONE;
          end else if (GAP_CYCLES > 0) begin
            state_nx = GAP;
            cnt_nx   = GAP_LD;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
      end
      GAP: begin
        drop = signal_in;
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // outputs are flops loaded from next state so pins never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      signal_out <= 1'b0;
      busy       <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      signal_out <= (state_nx == HOLD);
      busy       <= (state_nx != IDLE);
      if (clear_drops) begin
        drop_count <= 8'd0;
      end else if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_p2l_stretcher.sv
// tb_p2l_stretcher: three configurations driven in parallel, checked
// every cycle against a time-window reference model via a scoreboard.
module tb_p2l_stretcher;

  localparam int HP [3] = '{100, 100, 1};
  localparam int GP [3] = '{10, 10, 0};
  localparam bit RP [3] = '{1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signal_in = 1'b0;
  logic clear_drops = 1'b0;

  logic so0, so1, so2;
  logic bz0, bz1, bz2;
  logic [7:0] dc0, dc1, dc2;

  always #5 clk = ~clk;

  p2l_stretcher #(.HOLD_CYCLES(100), .GAP_CYCLES(10), .RETRIGGER(1'b1))
  dut_a (.clk(clk), .reset(reset), .signal_in(signal_in),
         .clear_drops(clear_drops), .signal_out(so0), .busy(bz0),
         .drop_count(dc0));

  p2l_stretcher #(.HOLD_CYCLES(100), .GAP_CYCLES(10), .RETRIGGER(1'b0))
  dut_b (.clk(clk), .reset(reset), .signal_in(signal_in),
         .clear_drops(clear_drops), .signal_out(so1), .busy(bz1),
         .drop_count(dc1));

  p2l_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .RETRIGGER(1'b0))
  dut_c (.clk(clk), .reset(reset), .signal_in(signal_in),
         .clear_drops(clear_drops), .signal_out(so2), .busy(bz2),
         .drop_count(dc2));

  typedef struct packed {
    logic [2:0]      out;
    logic [2:0]      busy;
    logic [2:0][7:0] dc;
    int unsigned     cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model: last accepted trigger edge per config; HOLD covers edges
  // k+1..k+H, GAP covers k+H+1..k+H+G, everything else is IDLE
  longint kk [3];
  bit     act [3];
  int     md [3];
  longint n = 0;

  task automatic chk(input string name, input int cyc,
                     input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s @%0d: got %0d expected %0d",
               name, cyc, got, want);
    end
  endtask

  task automatic cyc_drive(input logic s, input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    signal_in   = s;
    clear_drops = c;
    reset       = r;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      bit hold, gap, drop;
      hold = act[i] && (n >= kk[i] + 1) && (n <= kk[i] + HP[i]);
      gap  = act[i] && (n > kk[i] + HP[i]) &&
             (n <= kk[i] + HP[i] + GP[i]);
      if (r) begin
        act[i] = 1'b0;
        md[i]  = 0;
      end else begin
        drop = s && (gap || (hold && !RP[i]));
        if (s && !drop) begin
          act[i] = 1'b1;
          kk[i]  = n;
        end
        if (c) md[i] = 0;
        else if (drop && md[i] < 255) md[i]++;
      end
      e.out[i]  = act[i] && (n + 1 <= kk[i] + HP[i]);
      e.busy[i] = act[i] && (n + 1 <= kk[i] + HP[i] + GP[i]);
      e.dc[i]   = 8'(md[i]);
    end
    e.cyc = 32'(n);
    q.push_back(e);
    n++;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc_drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse();
    cyc_drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0] so, bz;
    logic [2:0][7:0] dc;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e  = q.pop_front();
        so = {so2, so1, so0};
        bz = {bz2, bz1, bz0};
        dc = {dc2, dc1, dc0};
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("signal_out[%0d]", i), int'(e.cyc),
              int'(so[i]), int'(e.out[i]));
          chk($sformatf("busy[%0d]", i), int'(e.cyc),
              int'(bz[i]), int'(e.busy[i]));
          chk($sformatf("drop_count[%0d]", i), int'(e.cyc),
              int'(dc[i]), int'(e.dc[i]));
        end
      end
    end
  end

  initial begin : stim
    int dens;
    for (int i = 0; i < 3; i++) begin
      kk[i] = 0; act[i] = 1'b0; md[i] = 0;
    end
    repeat (3) cyc_drive(1'b0, 1'b0, 1'b1);
    // single pulse
    idle(9); pulse(); idle(130);
    @(posedge clk); #3;
    chk("single_drops", 0, int'(dc0), 0);
    // retrigger at +50
    pulse(); idle(49); pulse(); idle(130);
    // no-retrigger: pulses at 0, 50, 105 (gap), 111 (first idle)
    pulse(); idle(49); pulse(); idle(54); pulse(); idle(5); pulse();
    idle(130);
    // pulse on final HOLD cycle
    pulse(); idle(99); pulse(); idle(220);
    // pulse on final GAP cycle, then first IDLE cycle
    pulse(); idle(109); pulse(); pulse(); idle(130);
    // HOLD=1/GAP=0 corners
    pulse(); pulse(); pulse(); idle(3);
    pulse(); idle(1); pulse(); idle(130);
    // saturation, then clear colliding with a drop
    repeat (300) pulse();
    @(posedge clk); #3;
    chk("saturate_b", 0, int'(dc1), 255);
    cyc_drive(1'b1, 1'b1, 1'b0);
    @(posedge clk); #3;
    chk("clear_a", 0, int'(dc0), 0);
    chk("clear_b", 0, int'(dc1), 0);
    chk("clear_c", 0, int'(dc2), 0);
    idle(130);
    // reset mid-HOLD with a trigger present during reset
    pulse(); idle(49); cyc_drive(1'b1, 1'b0, 1'b1);
    @(posedge clk); #3;
    chk("rst_out_a", 0, int'(so0), 0);
    chk("rst_busy_a", 0, int'(bz0), 0);
    idle(5); pulse(); idle(130);
    // randomized phase with varying trigger density
    dens = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: dens = 1;
          1: dens = 5;
          default: dens = 60;
        endcase
      end
      cyc_drive(($urandom_range(0, 99) < dens),
                ($urandom_range(0, 199) == 0),
                ($urandom_range(0, 999) == 0));
    end
    idle(2);
    @(posedge clk); #3;
    chk("queue_drain", 0, q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
